// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types for the front-end pipeline blocks.
// Holds the NOP encoding, control-flow opcodes and the predecode flag bundle.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic br;
    logic jal;
    logic jalr;
  } predecode_t;

endpackage

// File: rtl/rv32i_predecode.sv
// Combinational opcode classifier: flags conditional branches, JAL and JALR.
// Only instantiated by if_id_queue when IF_ID_PREDECODE_EN is defined.
module rv32i_predecode
  import rv32i_pkg::*;
(
  input  logic [6:0] i_opcode,
  output predecode_t o_flags
);

  always_comb begin
    o_flags      = '0;
    o_flags.br   = (i_opcode == OPC_BRANCH);
    o_flags.jal  = (i_opcode == OPC_JAL);
    o_flags.jalr = (i_opcode == OPC_JALR);
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction buffer: circular FIFO of {pc, instr} with early fetch stall.
// Optional head predecode flags are enabled by defining IF_ID_PREDECODE_EN.
module if_id_queue #(
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = DEPTH - 2,
  parameter int XLEN         = rv32i_pkg::XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  output logic                     stall_o,
  output logic                     valid_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          instr_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     br_o,
  output logic                     jal_o,
  output logic                     jalr_o
);

  import rv32i_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_CNT = CW'(STALL_THRESH);

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_instr [DEPTH];

  logic       w_valid;
  logic       w_pop;
  logic       w_push;
  predecode_t w_pd_head;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & ready_i & ~flush_i;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_push  = valid_i & ~flush_i & ((r_count < FULL_CNT) | w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (~w_push & w_pop) r_count <= r_count - CW'(1);
      if (valid_i & ~w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push & ~rst_i) begin
      r_pc[r_wr_ptr]    <= pc_i;
      r_instr[r_wr_ptr] <= instr_i;
    end
  end

`ifdef IF_ID_PREDECODE_EN
  predecode_t w_pd_in;
  predecode_t r_pd [DEPTH];

  rv32i_predecode u_predecode (
    .i_opcode (instr_i[6:0]),
    .o_flags  (w_pd_in)
  );

  always_ff @(posedge clk_i) begin
    if (w_push & ~rst_i) r_pd[r_wr_ptr] <= w_pd_in;
  end

  assign w_pd_head = w_valid ? r_pd[r_rd_ptr] : '0;
`else
  assign w_pd_head = '0;
`endif

  assign valid_o    = w_valid;
  assign stall_o    = (r_count >= THRESH_CNT);
  assign count_o    = r_count;
  assign overflow_o = r_overflow;
  assign pc_o       = w_valid ? r_pc[r_rd_ptr]    : '0;
  assign instr_o    = w_valid ? r_instr[r_rd_ptr] : XLEN'(NOP_INSTR);
  assign br_o       = w_pd_head.br;
  assign jal_o      = w_pd_head.jal;
  assign jalr_o     = w_pd_head.jalr;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: queue-based reference model, directed
// scenarios followed by randomized traffic with flushes and mid-run resets.
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int THRESH = DEPTH - 2;
  localparam int XLEN   = 32;
`ifdef IF_ID_PREDECODE_EN
  localparam bit PD_ON = 1'b1;
`else
  localparam bit PD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [XLEN-1:0] pc_i = '0, instr_i = '0;
  logic            stall_o, valid_o, overflow_o, br_o, jal_o, jalr_o;
  logic [XLEN-1:0] pc_o, instr_o;
  logic [$clog2(DEPTH):0] count_o;

  if_id_queue #(.DEPTH(DEPTH), .STALL_THRESH(THRESH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .stall_o(stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .instr_o(instr_o), .ready_i(ready_i), .count_o(count_o),
    .overflow_o(overflow_o), .br_o(br_o), .jal_o(jal_o), .jalr_o(jalr_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t modelQ[$];
  entry_t scoreQ[$];
  bit     modelOvf  = 1'b0;
  bit     modelLive = 1'b0;
  int     checks = 0;
  int     errors = 0;

  function automatic logic [2:0] expFlags(input logic [31:0] ins);
    logic [2:0] f;
    case (ins[6:0])
      7'h63:   f = 3'b100;
      7'h6F:   f = 3'b010;
      7'h67:   f = 3'b001;
      default: f = 3'b000;
    endcase
    return PD_ON ? f : 3'b000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy follows the queue rules directly; accepted
  // entries are also queued for the monitor to match against pops.
  always @(posedge clk) begin
    bit doPop, doPush;
    if (rst_i || flush_i) begin
      modelQ.delete();
      scoreQ.delete();
      modelOvf  = 1'b0;
      modelLive = modelLive | rst_i;
    end else if (modelLive) begin
      doPop  = (modelQ.size() > 0) && ready_i;
      doPush = valid_i && ((modelQ.size() < DEPTH) || doPop);
      if (doPop) void'(modelQ.pop_front());
      if (doPush) begin
        modelQ.push_back('{pc_i, instr_i});
        scoreQ.push_back('{pc_i, instr_i});
      end else if (valid_i) begin
        modelOvf = 1'b1;
      end
    end
  end

  // Monitor: status every cycle, head contents whenever decode takes an entry.
  always @(negedge clk) begin
    entry_t e;
    if (modelLive) begin
      checkOutput("count", 64'(count_o), 64'(modelQ.size()));
      checkOutput("valid", 64'(valid_o), 64'(modelQ.size() != 0));
      checkOutput("stall", 64'(stall_o), 64'(modelQ.size() >= THRESH));
      checkOutput("overflow", 64'(overflow_o), 64'(modelOvf));
      if (modelQ.size() == 0) begin
        checkOutput("empty_pc", 64'(pc_o), 64'h0);
        checkOutput("empty_instr", 64'(instr_o), 64'h13);
        checkOutput("empty_flags", 64'({br_o, jal_o, jalr_o}), 64'h0);
      end
      if (valid_o && ready_i && !flush_i && !rst_i) begin
        if (scoreQ.size() == 0) begin
          checkOutput("pop_unexpected", 64'(valid_o), 64'h0);
        end else begin
          e = scoreQ.pop_front();
          checkOutput("head_pc", 64'(pc_o), 64'(e.pc));
          checkOutput("head_instr", 64'(instr_o), 64'(e.instr));
          checkOutput("head_flags", 64'({br_o, jal_o, jalr_o}), 64'(expFlags(e.instr)));
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                               input logic rdy, input logic fl);
    valid_i = v;
    pc_i    = pc;
    instr_i = ins;
    ready_i = rdy;
    flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h13, rdy, 1'b0);
  endtask

  logic [31:0] fetchPc;
  logic        prevStall;
  logic [31:0] rnd;
  logic [6:0]  opc;

  initial begin
    rst_i = 1'b1;
    idle(1'b0, 2);
    rst_i = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i * 4), 32'h13, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Fetch emulation: the valid of this cycle answers the stall of the last.
    fetchPc   = 32'h0;
    prevStall = stall_o;
    for (int i = 0; i < 20; i++) begin
      logic v;
      v         = !prevStall;
      prevStall = stall_o;
      applyStimulus(v, fetchPc, 32'h13, (i >= 8), 1'b0);
      if (v) fetchPc += 32'h4;
    end
    idle(1'b1, 5);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h200 + 32'(i * 4), 32'h13, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 32'h300 + 32'(i * 4), 32'h13, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h40, 32'h13, 1'b0, 1'b0);
    idle(1'b0, 3);
    applyStimulus(1'b0, 32'h0, 32'h13, 1'b0, 1'b1);
    idle(1'b0, 1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h80 + 32'(i * 4), 32'h13, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h90, 32'h13, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h100, 32'h13, 1'b0, 1'b0);
    idle(1'b1, 2);

    applyStimulus(1'b1, 32'h500, 32'h00000063, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h504, 32'h0000006F, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h508, 32'h00000067, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h50C, 32'h00000013, 1'b0, 1'b0);
    idle(1'b1, 5);

    fetchPc   = 32'h1000;
    prevStall = stall_o;
    for (int i = 0; i < 600; i++) begin
      logic v, throttle;
      rnd = $urandom();
      case ($urandom_range(0, 4))
        0:       opc = 7'h63;
        1:       opc = 7'h6F;
        2:       opc = 7'h67;
        3:       opc = 7'h13;
        default: opc = rnd[6:0];
      endcase
      throttle  = (i % 200) < 150;
      v         = throttle ? (!prevStall && ($urandom_range(0, 3) != 0)) : ($urandom_range(0, 1) == 1);
      prevStall = stall_o;
      rst_i     = ($urandom_range(0, 149) == 0);
      applyStimulus(v, fetchPc, {rnd[31:7], opc}, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 39) == 0));
      fetchPc += 32'h4;
    end
    rst_i = 1'b0;
    idle(1'b1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
